// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline encodings: writeback result sources and load funct3 codes.
// The decoder and the writeback stage both import this package.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic isHalfLoad(input logic [2:0] funct3);
    return (funct3 == F3_LH) || (funct3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: picks the byte/halfword lane from the loaded word,
// sign- or zero-extends it, and flags misaligned half/word accesses.
module load_extend
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word[8*offset +: 8];
    halfSel = offset[1] ? word[31:16] : word[15:0];
    data    = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byteSel[7]}}, byteSel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byteSel};
      F3_LH:   data = {{(XLEN-16){halfSel[15]}}, halfSel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, halfSel};
      default: data = word;
    endcase
  end

  // Undefined funct3 codes fall through to the whole word without a flag.
  assign misalign = (isHalfLoad(funct3) && offset[0]) ||
                    ((funct3 == F3_LW) && (offset != 2'b00));

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB pipeline register plus writeback datapath: load extension, result
// select, register-file write enable, misaligned-load flag and retire counter.
module writeback_unit
  import pipeline_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ImmExtM,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ResultW,
  output logic              MisalignW,
  output logic [CNT_W-1:0]  InstRetW
);

  logic            regWriteR;
  result_src_e     srcR;
  logic [2:0]      funct3R;
  logic [XLEN-1:0] aluR;
  logic [XLEN-1:0] readDataR;
  logic [XLEN-1:0] pcPlus4R;
  logic [XLEN-1:0] immR;
  logic [XLEN-1:0] loadData;
  logic            loadMisalign;

  // The counter tracks departures from W, so a stalled or flushed-while-stalled
  // instruction is not counted; a plain flush still lets the old one leave.
  always_ff @(posedge clk) begin
    if (rst) begin
      ValidW    <= 1'b0;
      regWriteR <= 1'b0;
      srcR      <= RES_ALU;
      funct3R   <= '0;
      RdW       <= '0;
      aluR      <= '0;
      readDataR <= '0;
      pcPlus4R  <= '0;
      immR      <= '0;
      InstRetW  <= '0;
    end else begin
      if (ValidW && !StallW)
        InstRetW <= InstRetW + CNT_W'(1);
      if (FlushW) begin
        ValidW    <= 1'b0;
        regWriteR <= 1'b0;
      end else if (!StallW) begin
        ValidW    <= ValidM;
        regWriteR <= RegWriteM;
        srcR      <= result_src_e'(ResultSrcM);
        funct3R   <= Funct3M;
        RdW       <= RdM;
        aluR      <= ALU_ResultM;
        readDataR <= ReadDataM;
        pcPlus4R  <= PCPlus4M;
        immR      <= ImmExtM;
      end
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3   (funct3R),
    .offset   (aluR[1:0]),
    .word     (readDataR),
    .data     (loadData),
    .misalign (loadMisalign)
  );

  always_comb begin
    ResultW = aluR;
    case (srcR)
      RES_ALU:  ResultW = aluR;
      RES_LOAD: ResultW = loadData;
      RES_PC4:  ResultW = pcPlus4R;
      RES_IMM:  ResultW = immR;
      default:  ResultW = aluR;
    endcase
  end

  assign MisalignW = ValidW && (srcR == RES_LOAD) && loadMisalign;
  assign RegWriteW = ValidW && regWriteR && (RdW != '0) && !MisalignW;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed vectors push expected W state,
// a negedge monitor pops and compares; a CNT_W=4 copy exercises counter wrap.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;

  logic        ValidW, RegWriteW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [63:0] InstRetW;

  logic        sValidW, sRegWriteW, sMisalignW;
  logic [4:0]  sRdW;
  logic [31:0] sResultW;
  logic [3:0]  sInstRetW;

  typedef struct {
    logic        valid;
    logic        rw;
    logic        mis;
    logic        chk;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [63:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          fails = 0;
  logic        modelValid = 1'b0;
  logic [63:0] modelCnt = '0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .MisalignW(MisalignW), .InstRetW(InstRetW)
  );

  writeback_unit #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .ValidW(sValidW), .RegWriteW(sRegWriteW), .RdW(sRdW),
    .ResultW(sResultW), .MisalignW(sMisalignW), .InstRetW(sInstRetW)
  );

  task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("ValidW", 64'(ValidW), 64'(e.valid));
    compare("RegWriteW", 64'(RegWriteW), 64'(e.rw));
    compare("MisalignW", 64'(MisalignW), 64'(e.mis));
    compare("InstRetW", InstRetW, e.cnt);
    compare("InstRetW_w4", 64'(sInstRetW), 64'(e.cnt[3:0]));
    if (e.chk) begin
      compare("RdW", 64'(RdW), 64'(e.rd));
      compare("ResultW", 64'(ResultW), 64'(e.res));
    end
  endtask

  // Drive one cycle, then record what W must look like after this edge.
  task automatic applyStimulus(
    input logic r, input logic f, input logic s, input logic vm, input logic rwm,
    input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
    input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
    input logic [31:0] imm, input logic expRw, input logic [4:0] expRd,
    input logic [31:0] expRes, input logic expMis, input logic chk);
    exp_t e;
    rst = r; FlushW = f; StallW = s; ValidM = vm; RegWriteM = rwm;
    ResultSrcM = src; Funct3M = f3; RdM = rd;
    ALU_ResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
    @(posedge clk);
    if (r) begin
      modelValid = 1'b0;
      modelCnt   = '0;
    end else begin
      if (modelValid && !s) modelCnt = modelCnt + 64'd1;
      if (f) modelValid = 1'b0;
      else if (!s) modelValid = vm;
    end
    e.valid = modelValid;
    e.rw    = expRw & modelValid;
    e.mis   = expMis & modelValid;
    e.chk   = chk;
    e.rd    = expRd;
    e.res   = expRes;
    e.cnt   = modelCnt;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    rst = 1'b1; StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b0; RegWriteM = 1'b0;
    ResultSrcM = '0; Funct3M = '0; RdM = '0;
    ALU_ResultM = '0; ReadDataM = '0; PCPlus4M = '0; ImmExtM = '0;
    @(negedge clk);
    //             r f s v w src    f3      rd     alu           rdata          pc4           imm           eRw eRd    eRes          eMis chk
    applyStimulus(1,0,0,0,0,2'b00,3'b000,5'd0, 32'h0,        32'h0,         32'h0,        32'h0,        0,5'd0, 32'h0,        0,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b000,5'd5, 32'h3,        32'h80FF_1234, 32'h0,        32'h0,        1,5'd5, 32'hFFFF_FF80,0,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b100,5'd6, 32'h100,      32'h80FF_1234, 32'h0,        32'h0,        1,5'd6, 32'h0000_0034,0,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b001,5'd7, 32'h1,        32'h80FF_1234, 32'h0,        32'h0,        0,5'd7, 32'h0000_1234,1,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b101,5'd8, 32'h2,        32'h8001_0000, 32'h0,        32'h0,        1,5'd8, 32'h0000_8001,0,1);
    applyStimulus(0,0,0,1,1,2'b10,3'b000,5'd1, 32'h9,        32'h0,         32'h0000_0104,32'h0,        1,5'd1, 32'h0000_0104,0,1);
    applyStimulus(0,0,0,1,1,2'b00,3'b000,5'd0, 32'hDEAD_BEEF,32'h0,         32'h0,        32'h0,        0,5'd0, 32'hDEAD_BEEF,0,1);
    applyStimulus(0,0,0,1,1,2'b11,3'b000,5'd9, 32'h0,        32'h0,         32'h0,        32'h1234_5000,1,5'd9, 32'h1234_5000,0,1);
    for (int i = 0; i < 3; i++)
      applyStimulus(0,0,1,1,1,2'b00,3'b000,5'd3, 32'h55,     32'h0,         32'h0,        32'h0,        1,5'd9, 32'h1234_5000,0,1);
    applyStimulus(0,0,0,1,1,2'b00,3'b000,5'd10,32'hAA,       32'h0,         32'h0,        32'h0,        1,5'd10,32'h0000_00AA,0,1);
    applyStimulus(0,1,1,1,1,2'b00,3'b000,5'd4, 32'h66,       32'h0,         32'h0,        32'h0,        0,5'd0, 32'h0,        0,0);
    applyStimulus(0,0,0,1,1,2'b01,3'b010,5'd11,32'h40,       32'hCAFE_F00D, 32'h0,        32'h0,        1,5'd11,32'hCAFE_F00D,0,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b010,5'd12,32'h42,       32'h1122_3344, 32'h0,        32'h0,        0,5'd12,32'h1122_3344,1,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b011,5'd13,32'h43,       32'hA5A5_A5A5, 32'h0,        32'h0,        1,5'd13,32'hA5A5_A5A5,0,1);
    applyStimulus(0,0,0,1,1,2'b01,3'b001,5'd14,32'h2,        32'h8001_0000, 32'h0,        32'h0,        1,5'd14,32'hFFFF_8001,0,1);
    applyStimulus(0,1,0,1,1,2'b00,3'b000,5'd2, 32'h11,       32'h0,         32'h0,        32'h0,        0,5'd0, 32'h0,        0,0);
    applyStimulus(0,0,0,1,1,2'b00,3'b000,5'd15,32'h77,       32'h0,         32'h0,        32'h0,        1,5'd15,32'h0000_0077,0,1);
    applyStimulus(1,0,1,1,1,2'b00,3'b000,5'd16,32'h88,       32'h0,         32'h0,        32'h0,        0,5'd0, 32'h0,        0,1);
    applyStimulus(0,0,0,0,1,2'b00,3'b000,5'd17,32'h99,       32'h0,         32'h0,        32'h0,        0,5'd0, 32'h0,        0,0);
    // Seventeen back-to-back ALU writes: the 4-bit counter runs 0..15 then wraps to 0.
    for (int i = 0; i < 17; i++)
      applyStimulus(0,0,0,1,1,2'b00,3'b000,5'(i+1),32'(i*3+1),32'h0,       32'h0,        32'h0,        1,5'(i+1),32'(i*3+1),0,1);
    for (int i = 0; i < 2; i++)
      applyStimulus(0,0,0,0,0,2'b00,3'b000,5'd0, 32'h0,      32'h0,         32'h0,        32'h0,        0,5'd0, 32'h0,        0,0);
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised MEM/WB pipeline register plus writeback datapath for the RV32I pipeline, replacing the purely combinational writeback stage. It registers memory-stage results, aligns and sign- or zero-extends load data by funct3 and byte offset, and selects among four result sources. It also drives the register-file write port (x0 writes suppressed), flags misaligned loads, and keeps a retired-instruction counter. It sits between the memory stage and the register file / hazard unit.

## Interface
- XLEN, 32, datapath width (32 only in this generation; byte-lane logic assumes 4 lanes)
- REG_AW, 5, register address width
- CNT_W, 64, retired-instruction counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- StallW  in  1  hold the MEM/WB register contents
- FlushW  in  1  insert a bubble into W
- ValidM  in  1  memory-stage instruction is real (not a bubble)
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 ImmExt (LUI)
- Funct3M  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- RdM  in  REG_AW  destination register
- ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM  in  XLEN each  stage results; ReadDataM is the aligned memory word
- ValidW  out  1  W holds a real instruction
- RegWriteW  out  1  register-file write enable
- RdW  out  REG_AW  register-file write address
- ResultW  out  XLEN  register-file write data, also the forwarding source
- MisalignW  out  1  W holds a misaligned load
- InstRetW  out  CNT_W  retired-instruction count

## Operation
- MEM/WB register holds the M-suffixed inputs. Priority on each edge: rst > FlushW > StallW > load.
  - Flush and reset clear ValidW and the stored RegWrite. Stored data fields are don't-care.
  - Stall holds every field.
- Load extraction, from the stored ALU_Result[1:0] (offset):
  - LB/LBU select byte lane offset (bits 8*offset+7:8*offset), then sign- or zero-extend.
  - LH/LHU select halfword offset[1], then sign- or zero-extend.
  - LW takes the whole word.
  - Undefined funct3 with ResultSrc=01 yields the whole word; no flag is raised.
- Misalignment: MisalignW = ValidW & ResultSrc==01 & ((half type & offset[0]) | (LW & offset!=00)).
- ResultW: 4:1 mux on the stored ResultSrc, combinational from the register.
- RegWriteW = ValidW & stored RegWrite & (RdW != 0) & !MisalignW.
- InstRetW increments by 1 on each edge where ValidW=1 and StallW=0 (the instruction leaves W). It wraps from all-ones to 0.

## Timing
- One-cycle latency: M inputs sampled at edge N appear on W outputs after edge N. W outputs are combinational from registered state only; there is no M→W combinational path.
- Reset values: ValidW=0, RegWriteW=0, RdW=0, ResultW=0 (stored fields cleared on reset), MisalignW=0, InstRetW=0.
- Flush and stall asserted together: flush wins, and the counter does not increment on that edge if ValidW was 1. Only stall-free departures count.
- Reset mid-stall: bubble on the next cycle and counter zeroed.
- Forwarding consumers may use ResultW in the same cycle RegWriteW=1.

## Structure
- Shared package (pipeline_pkg): ResultSrc encodings (RES_ALU/RES_LOAD/RES_PC4/RES_IMM) and funct3 load constants (F3_LB…F3_LHU), shared with the decoder.
- One sub-module: load_extend (combinational; inputs funct3, offset, word; outputs extended data and misalign flag). The 4:1 mux stays inline.

## Test plan
- LB at offset 3 with ReadDataM=0x80FF_1234 → ResultW=0xFFFF_FF80. The same word with LBU at offset 0 → 0x0000_0034.
- LH at offset 1 → MisalignW=1, RegWriteW=0, InstRetW still increments. LHU at offset 2 with 0x8001_0000 → 0x0000_8001.
- ResultSrc 10 with PCPlus4M=0x0000_0104 and RdM=1 → ResultW=0x104, RegWriteW=1. RdM=0 with RegWriteM=1 → RegWriteW=0.
- StallW held 3 cycles with a valid LUI (ImmExt=0x1234_5000) in W → outputs constant and InstRetW unchanged, then +1 on release. FlushW and StallW together → ValidW=0 next cycle.
- rst asserted mid-stream → all outputs 0 after the next edge. Preload the counter near wrap (CNT_W=4 build) with 16 retirements → InstRetW wraps from 15 to 0.
